ram_arbiter: RTL

- Shares the single-port data RAM between up to `numRequesters` memory clients, such as per-core Io units and the channel unit.
- Serves one RAM operation at a time, chosen by round-robin arbitration.
- Latches each request, drives the RAM for exactly one cycle, returns read data and pulses a per-requester done strobe.
- Sits between the processor cores/channel unit and the RAM macro.

---
 rtl/ram_arbiter_pkg.sv | 26 ++
 rtl/ram_arbiter_rr_priority_select.sv | 37 +++
 rtl/ram_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the data-RAM arbiter: RAM op encoding, default widths,
// FSM state encoding and the index-wrap helper used by the round-robin scan.
package ram_arbiter_pkg;

    localparam int ADDRESS_BITS = 16;
    localparam int DATA_BITS    = 16;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = STATE_IDLE,
        ST_ACCESS = STATE_ACCESS,
        ST_DONE   = STATE_DONE
    } state_e;

    // Callers only ever pass idx < 2*n, so one conditional subtract is a full modulo.
    function automatic int wrap_index(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set request bit after lastGrant,
// wrapping modulo numRequesters so non-power-of-two counts never pick a ghost client.
module rr_priority_select
    import ram_arbiter_pkg::*;
#(
    parameter int numRequesters = 4,
    parameter int idxBits       = $clog2(numRequesters)
) (
    input  logic [numRequesters-1:0] req,
    input  logic [idxBits-1:0]       lastGrant,
    output logic [idxBits-1:0]       grant,
    output logic                     anyReq
);

    logic [idxBits-1:0] cand;
    logic               found;
    int                 pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        pos   = 0;
        // Offset 1 is the client right after the last winner, offset N is the last winner itself.
        for (int k = 1; k <= numRequesters; k++) begin
            pos  = wrap_index(int'(lastGrant) + k, numRequesters);
            cand = idxBits'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign anyReq = |req;

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: latches one client request in IDLE, drives the RAM
// for one ACCESS cycle, then acks the client and captures read data in DONE.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int addrBits      = ADDRESS_BITS,
    parameter int dataBits      = DATA_BITS,
    parameter int numRequesters = 4,
    localparam int idxBits      = $clog2(numRequesters)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [numRequesters-1:0]           req,
    input  logic [numRequesters-1:0]           reqRW,
    input  logic [numRequesters*addrBits-1:0]  reqAddr,
    input  logic [numRequesters*dataBits-1:0]  reqData,
    output logic [numRequesters-1:0]           ack,
    output logic [dataBits-1:0]                readData,
    output logic [addrBits-1:0]                ramAddr,
    output logic [dataBits-1:0]                ramDataIn,
    output logic                               ramRW,
    input  logic [dataBits-1:0]                ramDataOut,
    output logic                               busy
);

    state_e              state_q, state_d;
    logic [idxBits-1:0]  last_grant_q, last_grant_d;
    logic [idxBits-1:0]  grant_q, grant_d;
    logic                rw_q, rw_d;
    logic [addrBits-1:0] addr_q, addr_d;
    logic [dataBits-1:0] data_q, data_d;
    logic [dataBits-1:0] read_data_q, read_data_d;

    logic [idxBits-1:0]  sel_grant;
    logic                any_req;

    rr_priority_select #(
        .numRequesters (numRequesters),
        .idxBits       (idxBits)
    ) u_select (
        .req       (req),
        .lastGrant (last_grant_q),
        .grant     (sel_grant),
        .anyReq    (any_req)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        read_data_d  = read_data_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = sel_grant;
                    rw_d    = reqRW[sel_grant];
                    addr_d  = reqAddr[int'(sel_grant)*addrBits +: addrBits];
                    data_d  = reqData[int'(sel_grant)*dataBits +: dataBits];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE: begin
                // RAM output reflects the address presented during ACCESS.
                if (rw_q == RAM_READ)
                    read_data_d = ramDataOut;
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= idxBits'(numRequesters - 1);
            grant_q      <= '0;
            rw_q         <= RAM_READ;
            addr_q       <= '0;
            data_q       <= '0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            read_data_q  <= read_data_d;
        end
    end

    // RAM-facing outputs are gated by reset so an abort forces a read in the same cycle.
    always_comb begin
        ack = '0;
        if (reset && state_q == ST_DONE)
            ack[grant_q] = 1'b1;
    end

    assign ramRW     = (reset && state_q == ST_ACCESS && rw_q == RAM_WRITE) ? RAM_WRITE : RAM_READ;
    assign ramAddr   = reset ? addr_q : '0;
    assign ramDataIn = reset ? data_q : '0;
    assign readData  = read_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
